seven_seg_scan_reader: RTL and testbench

//  Receive side of the board seven-segment interface. Monitors a multiplexed 4-digit

---
 rtl/seven_seg_scan_reader.sv | 208 ++++++++++++++++++++
 tb/tb_seven_seg_scan_reader.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan_reader.sv
// seven_seg_scan_reader: recovers hex digits from a scanned 7-seg bus.
// Define BLANK_DETECT_EN to add all-segments-off detection on BLANK[3:0].
module seven_seg_scan_reader #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic        A,
  input  logic        B,
  input  logic        C,
  input  logic        D,
  input  logic        E,
  input  logic        F,
  input  logic        G,
  input  logic [3:0]  AN,
  output logic [15:0] HEX,
  output logic [3:0]  DVALID,
  output logic [3:0]  ERR,
`ifdef BLANK_DETECT_EN
  output logic [3:0]  BLANK,
`endif
  output logic        UPD
);

  localparam int CW = (STABLE_CYCLES > 2) ?
                      $clog2(STABLE_CYCLES) : 1;
  // sample/prev pipeline already covers two of the stable edges
  localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 2);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    HELD
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;

  logic [3:0] smp_an, prv_an;
  logic [6:0] smp_seg, prv_seg;
  logic       same;
  logic       an_ok;
  logic [1:0] idx;
  logic       cap;
  logic [4:0] dec;

  logic [15:0] hex_n;
  logic [3:0]  dvalid_n;
  logic [3:0]  err_n;
  logic        upd_n;
`ifdef BLANK_DETECT_EN
  logic [3:0]  blank_n;
`endif

  function automatic logic [4:0] seg_decode(
    input logic [6:0] s
  );
    logic [4:0] r;
    r = 5'b0_0000;
    case (s)
      7'b0000001: r = {1'b1, 4'h0};
      7'b1001111: r = {1'b1, 4'h1};
      7'b0010010: r = {1'b1, 4'h2};
      7'b0000110: r = {1'b1, 4'h3};
      7'b1001100: r = {1'b1, 4'h4};
      7'b0100100: r = {1'b1, 4'h5};
      7'b0100000: r = {1'b1, 4'h6};
      7'b0001111: r = {1'b1, 4'h7};
      7'b0000000: r = {1'b1, 4'h8};
      7'b0001100: r = {1'b1, 4'h9};
      7'b0001000: r = {1'b1, 4'hA};
      7'b1100000: r = {1'b1, 4'hB};
      7'b0110001: r = {1'b1, 4'hC};
      7'b1000010: r = {1'b1, 4'hD};
      7'b0110000: r = {1'b1, 4'hE};
      7'b0111000: r = {1'b1, 4'hF};
      default:    r = 5'b0_0000;
    endcase
    return r;
  endfunction

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      smp_an  <= 4'hF;
      smp_seg <= 7'h7F;
      prv_an  <= 4'hF;
      prv_seg <= 7'h7F;
    end else begin
      smp_an  <= AN;
      smp_seg <= {A, B, C, D, E, F, G};
      prv_an  <= smp_an;
      prv_seg <= smp_seg;
    end
  end

  assign same = ({smp_an, smp_seg} == {prv_an, prv_seg});
  assign dec  = seg_decode(smp_seg);

  always_comb begin
    an_ok = 1'b1;
    idx   = 2'd0;
    case (smp_an)
      4'b1110: idx   = 2'd0;
      4'b1101: idx   = 2'd1;
      4'b1011: idx   = 2'd2;
      4'b0111: idx   = 2'd3;
      default: an_ok = 1'b0;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    cap     = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_n = '0;
        if (an_ok) state_n = SETTLE;
      end
      SETTLE: begin
        if (!an_ok) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (!same) begin
          cnt_n = '0;
        end else if (cnt == LAST) begin
          cap     = 1'b1;
          state_n = HELD;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      HELD: begin
        cnt_n = '0;
        if (!an_ok) state_n = IDLE;
        else if (!same) state_n = SETTLE;
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  always_comb begin
    hex_n    = HEX;
    dvalid_n = DVALID;
    err_n    = ERR;
`ifdef BLANK_DETECT_EN
    blank_n  = BLANK;
`endif
    if (cap) begin
      if (dec[4]) begin
        hex_n[{idx, 2'b00} +: 4] = dec[3:0];
        dvalid_n[idx] = 1'b1;
        err_n[idx]    = 1'b0;
`ifdef BLANK_DETECT_EN
        blank_n[idx]  = 1'b0;
      end else if (smp_seg == 7'h7F) begin
        blank_n[idx] = 1'b1;
        err_n[idx]   = 1'b0;
`endif
      end else begin
        err_n[idx] = 1'b1;
      end
    end
  end

`ifdef BLANK_DETECT_EN
  assign upd_n = {hex_n, dvalid_n, err_n, blank_n}
              != {HEX, DVALID, ERR, BLANK};
`else
  assign upd_n = {hex_n, dvalid_n, err_n}
              != {HEX, DVALID, ERR};
`endif

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      HEX    <= 16'h0000;
      DVALID <= 4'b0000;
      ERR    <= 4'b0000;
      UPD    <= 1'b0;
`ifdef BLANK_DETECT_EN
      BLANK  <= 4'b0000;
`endif
    end else begin
      HEX    <= hex_n;
      DVALID <= dvalid_n;
      ERR    <= err_n;
      UPD    <= upd_n;
`ifdef BLANK_DETECT_EN
      BLANK  <= blank_n;
`endif
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_reader.sv
// Directed bench for seven_seg_scan_reader.
// Build with BLANK_DETECT_EN to exercise the BLANK output.
module tb_seven_seg_scan_reader;

  logic        Clock = 1'b0;
  logic        Resetn;
  logic        A, B, C, D, E, F, G;
  logic [3:0]  AN;
  logic [15:0] HEX;
  logic [3:0]  DVALID;
  logic [3:0]  ERR;
  logic        UPD;
`ifdef BLANK_DETECT_EN
  logic [3:0]  BLANK;
`endif
  logic [6:0]  seg;

  int n_chk   = 0;
  int n_fail  = 0;
  int upd_cnt = 0;

  assign {A, B, C, D, E, F, G} = seg;

  always #5 Clock = ~Clock;

  seven_seg_scan_reader dut (
    .Clock  (Clock),
    .Resetn (Resetn),
    .A      (A),
    .B      (B),
    .C      (C),
    .D      (D),
    .E      (E),
    .F      (F),
    .G      (G),
    .AN     (AN),
    .HEX    (HEX),
    .DVALID (DVALID),
    .ERR    (ERR),
`ifdef BLANK_DETECT_EN
    .BLANK  (BLANK),
`endif
    .UPD    (UPD)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge Clock);
      if (UPD === 1'b1) upd_cnt++;
    end
  endtask

  task automatic show(input logic [3:0] an,
                      input logic [6:0] s,
                      input int n);
    AN  = an;
    seg = s;
    tick(n);
  endtask

  task automatic scan();
    show(4'b1110, 7'b1001111, 8);
    show(4'b1101, 7'b0010010, 8);
    show(4'b1011, 7'b0000110, 8);
    show(4'b0111, 7'b0111000, 8);
  endtask

  initial begin
    Resetn = 1'b0;
    AN     = 4'hF;
    seg    = 7'h7F;
    tick(2);
    check("rst_hex", 32'(HEX), 32'h0);
    check("rst_dvalid", 32'(DVALID), 32'h0);
    check("rst_err", 32'(ERR), 32'h0);
    check("rst_upd", 32'(UPD), 32'h0);
    Resetn = 1'b1;
    tick(2);

    // single digit '2' on AN0
    AN  = 4'b1110;
    seg = 7'b0010010;
    tick(4);
    check("t1_hex_early", 32'(HEX), 32'h0);
    check("t1_upd_early", 32'(UPD), 32'h0);
    tick(1);
    check("t1_hex", 32'(HEX), 32'h0002);
    check("t1_dvalid", 32'(DVALID), 32'h1);
    check("t1_err", 32'(ERR), 32'h0);
    check("t1_upd", 32'(UPD), 32'h1);
    tick(1);
    check("t1_upd_drop", 32'(UPD), 32'h0);
    tick(4);
    check("t1_upd_held", 32'(UPD), 32'h0);
    check("t1_hex_held", 32'(HEX), 32'h0002);

    // full scan, then an identical one
    upd_cnt = 0;
    scan();
    check("t2_upd_cnt", 32'(upd_cnt), 32'd4);
    check("t2_hex", 32'(HEX), 32'hF321);
    check("t2_dvalid", 32'(DVALID), 32'hF);
    check("t2_err", 32'(ERR), 32'h0);
    upd_cnt = 0;
    scan();
    check("t2_rescan_upd", 32'(upd_cnt), 32'd0);
    check("t2_rescan_hex", 32'(HEX), 32'hF321);

    // illegal pattern on digit 1, then a legal one
    upd_cnt = 0;
    show(4'b1101, 7'b1111110, 8);
    check("t3_err", 32'(ERR), 32'h2);
    check("t3_hex", 32'(HEX), 32'hF321);
    check("t3_dvalid", 32'(DVALID), 32'hF);
    check("t3_upd_cnt", 32'(upd_cnt), 32'd1);
    show(4'b1101, 7'b0000000, 8);
    check("t3_hex8", 32'(HEX), 32'hF381);
    check("t3_err_clr", 32'(ERR), 32'h0);

    // short glitches and multi-digit enable
    upd_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      show(4'b1110, 7'b0000000, 3);
      show(4'b1110, 7'b0001100, 3);
    end
    show(4'b1100, 7'b0000000, 10);
    check("t4_upd_cnt", 32'(upd_cnt), 32'd0);
    check("t4_hex", 32'(HEX), 32'hF381);
    check("t4_err", 32'(ERR), 32'h0);
    show(4'b1111, 7'h7F, 4);

    // reset mid-SETTLE
    show(4'b1110, 7'b0000110, 2);
    Resetn = 1'b0;
    #1;
    check("t5_hex_async", 32'(HEX), 32'h0);
    check("t5_dvalid_async", 32'(DVALID), 32'h0);
    check("t5_err_async", 32'(ERR), 32'h0);
    tick(2);
    Resetn = 1'b1;
    tick(4);
    check("t5_hex_early", 32'(HEX), 32'h0);
    tick(1);
    check("t5_hex", 32'(HEX), 32'h0003);
    check("t5_upd", 32'(UPD), 32'h1);
    // reset while UPD is high
    Resetn = 1'b0;
    #1;
    check("t5_upd_async", 32'(UPD), 32'h0);
    check("t5_hex_async2", 32'(HEX), 32'h0);
    tick(1);
    Resetn = 1'b1;
    tick(4);
    check("t5_hex_early2", 32'(HEX), 32'h0);
    tick(1);
    check("t5_hex2", 32'(HEX), 32'h0003);
    check("t5_dvalid2", 32'(DVALID), 32'h1);

    // all segments off on digit 3
    show(4'b0111, 7'h7F, 8);
`ifdef BLANK_DETECT_EN
    check("t6_blank", 32'(BLANK), 32'h8);
    check("t6_err", 32'(ERR), 32'h0);
`else
    check("t6_err", 32'(ERR), 32'h8);
`endif
    check("t6_hex", 32'(HEX), 32'h0003);
    check("t6_dvalid", 32'(DVALID), 32'h1);
    show(4'b0111, 7'b0000000, 8);
`ifdef BLANK_DETECT_EN
    check("t6_blank_clr", 32'(BLANK), 32'h0);
`endif
    check("t6_hex8", 32'(HEX), 32'h8003);
    check("t6_err_clr", 32'(ERR), 32'h0);
    check("t6_dvalid9", 32'(DVALID), 32'h9);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
